fp16_dot_mac: RTL and testbench
===============================

# fp16_dot_mac

Streaming FP16 dot-product accumulator: it multiplies LEN operand pairs and sums the products into a single FP16 result. It uses valid/ready handshakes on input and output, a start/length command and a product FIFO. The block instantiates the team's fp16multiplier and fp16adder and sits between an operand streamer and a result sink. It generalises the free-running MAC into a counted, back-pressured, latency-parametrised unit with an accumulator-keep mode.

## Interface
- LEN_W, 8: width of the pair-count field.
- FIFO_DEPTH, 4: product FIFO entries; must be a power of two and at least MUL_LAT+1.
- MUL_LAT, 1: register latency of the instantiated fp16multiplier.
- ADD_LAT, 1: register latency of the instantiated fp16adder.
- CLK  in  1  clock, rising edge.
- RESETn  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- len  in  LEN_W  number of pairs to accumulate; sampled with start.
- keep_acc  in  1  sampled with start: 1 continues from the current acc, 0 starts from 16'h0000.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pair accepted when in_valid & in_ready.
- a, b  in  16  FP16 operands.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  16  FP16 accumulated result.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: accepts pairs and accumulates products.
  - DONE: presents the result.
- IDLE -> RUN on start with len != 0.
- IDLE -> DONE on start with len == 0; out_data is the initial acc.
- RUN -> DONE when the consumed-product count equals len.
- DONE -> IDLE on the output handshake.
- start outside IDLE is ignored, as are len and keep_acc.
- Counters:
  - issued counts pairs accepted.
  - consumed counts adds retired.
  - Both are LEN_W+... bits wide enough to hold len; both clear on entering RUN.
- in_ready = RUN & (issued < len) & (fifo_count + mul_inflight < FIFO_DEPTH).
  - This credit rule guarantees a FIFO write never occurs when the FIFO is full.
- A handshake feeds a/b into the multiplier and tags the pair in a MUL_LAT-deep valid shift register.
- The product is written to the FIFO when its tag exits the shift register.
- Accumulation loop (one add in flight at a time):
  - When acc_free and the FIFO is non-empty: pop, present (acc, product) to the adder, clear acc_free.
  - When the matching ADD_LAT tag emerges: acc <= adder result, consumed += 1, acc_free set.
- Arithmetic is defined by the fp16multiplier/fp16adder instances. No extra rounding, flushing or saturation is applied here.
- out_data is driven from acc and is stable throughout DONE. acc is retained after DONE for a later keep_acc=1 command.
- A simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- Reset mid-operation:
  - All state returns to reset values, including the FIFO, tags and counters.
  - Products in flight in the submodules are discarded, because the tags are cleared.

## Timing
- Reset values: state IDLE; busy 0; in_ready 0; out_valid 0; out_data 16'h0000; acc 16'h0000; FIFO empty.
- start accepted in cycle t gives busy=1 from t+1. The first pair handshake is possible in t+1.
- Pair handshake in cycle k:
  - product valid in k+MUL_LAT, in the FIFO from k+MUL_LAT+1;
  - earliest add issue is k+MUL_LAT+1; acc is updated at the end of k+MUL_LAT+1+ADD_LAT.
- With the FIFO non-empty, an add issues every ADD_LAT+1 cycles; that is the sustained throughput.
- Last acc update in cycle d gives out_valid=1 in d+1.
- For len=1 with both latencies at 1: handshake in cycle 1, out_valid in cycle 5.
- len=0: start in t gives out_valid in t+1.
- out_valid stays high, with out_data unchanged, until out_ready. The state is IDLE in the cycle after the handshake. start is accepted in that cycle at the earliest.

## Test plan
- **Basic dot product.** keep_acc=0, len=3, pairs (3C00,4000), (4000,4000), (3800,4000).
  - Required: out_data=16'h4700 (7.0); exactly 3 input handshakes; in_ready=0 after the third.
- **Keep-acc continuation.** Immediately after the previous test: keep_acc=1, len=1, pair (3C00,3C00).
  - Required: out_data=16'h4800 (8.0).
- **Zero length.** keep_acc=0, len=0.
  - Required: out_valid in the cycle after start, out_data=16'h0000, no in_ready pulse.
- **Back-pressure.** len=8, all pairs (3C00,3C00), in_valid held high, out_ready low for 5 cycles after out_valid.
  - Required: in_ready drops while the FIFO credit is exhausted, no pair is lost or duplicated, and out_data=16'h4800 held stable until out_ready.
- **Reset mid-run.** RESETn pulsed low after 2 of 4 pairs are accepted.
  - Required: all outputs at reset values on the same edge.
  - Then a command with len=1, pair (4000,4200) must give 16'h4600 (6.0) with no stale product.
- **Start while busy.** A start pulse during RUN with len=5 and keep_acc=1.
  - Required: it is ignored; the original len completes with the original result.

Source files
------------

// File: rtl/fp16_dot_mac_if.sv
// rtl/fp16_dot_mac_if.sv - command, operand and result handshake bundle for fp16_dot_mac
//
// Ports (master = operand streamer / result sink, slave = fp16_dot_mac):
//   start, len, keep_acc   command strobe, pair count, continue-from-acc flag
//   busy                   high whenever the engine is not idle
//   in_valid, in_ready     operand pair handshake carrying a, b (FP16)
//   out_valid, out_ready   result handshake carrying out_data (FP16)
interface fp16_dot_mac_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             keep_acc;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;

    modport master (
        output start, len, keep_acc, in_valid, a, b, out_ready,
        input  busy, in_ready, out_valid, out_data
    );

    modport slave (
        input  start, len, keep_acc, in_valid, a, b, out_ready,
        output busy, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp16_dot_mac.sv
// rtl/fp16_dot_mac.sv - counted, back-pressured FP16 dot-product accumulator
//
// fp16multiplier: FP16 product, round-to-nearest-even, LAT register stages.
//   CLK, RESETn, a, b in; p out.
// fp16adder: FP16 sum, round-to-nearest-even, LAT register stages.
//   CLK, RESETn, a, b in; s out.
// Both treat zero-exponent inputs as signed zero, flush underflow to signed
// zero, saturate overflow to infinity and return 16'h7E00 for invalid ops.
//
// fp16_dot_mac: CLK, RESETn (async, active-low) and bus (fp16_dot_mac_if.slave).
//   Accepts len operand pairs, multiplies each pair, and folds the products into
//   acc one add at a time through a product FIFO; presents acc on out_data.

module fp16multiplier #(
    parameter int LAT = 1
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);
    logic              s, za, zb, na, nb, nan;
    logic [4:0]        ea, eb;
    logic [9:0]        ma, mb, mant, mant_r;
    logic [21:0]       xa, xb, prod;
    logic              grd, stk, rnd;
    logic signed [7:0] e_raw, e_norm, e_rnd;
    logic [15:0]       res;
    logic [15:0]       pipe [LAT];

    always_comb begin
        s      = a[15] ^ b[15];
        ea     = a[14:10];
        eb     = b[14:10];
        ma     = a[9:0];
        mb     = b[9:0];
        za     = (ea == 5'd0);
        zb     = (eb == 5'd0);
        na     = (ea == 5'd31);
        nb     = (eb == 5'd31);
        nan    = (na && ma != 10'd0) || (nb && mb != 10'd0) || (na && zb) || (nb && za);
        xa     = {11'd0, 1'b1, ma};
        xb     = {11'd0, 1'b1, mb};
        prod   = xa * xb;
        e_raw  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
        // The 11x11 significand product lies in [2^20, 2^22); bit 21 means one
        // extra binade.
        if (prod[21]) begin
            mant   = prod[20:11];
            grd    = prod[10];
            stk    = |prod[9:0];
            e_norm = e_raw + 8'sd1;
        end else begin
            mant   = prod[19:10];
            grd    = prod[9];
            stk    = |prod[8:0];
            e_norm = e_raw;
        end
        rnd    = grd & (stk | mant[0]);
        mant_r = mant + {9'd0, rnd};
        e_rnd  = (rnd && mant == 10'h3FF) ? e_norm + 8'sd1 : e_norm;

        if (nan)                 res = 16'h7E00;
        else if (na || nb)       res = {s, 5'h1F, 10'h000};
        else if (za || zb)       res = {s, 15'h0000};
        else if (e_rnd >= 8'sd31) res = {s, 5'h1F, 10'h000};
        else if (e_rnd <= 8'sd0)  res = {s, 15'h0000};
        else                     res = {s, e_rnd[4:0], mant_r};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= 16'h0000;
        end else begin
            pipe[0] <= res;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign p = pipe[LAT-1];
endmodule

module fp16adder #(
    parameter int LAT = 1
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s
);
    logic [15:0]       x, y;
    logic [4:0]        ex, ey, d;
    logic              xnan, ynan, xi, yi, eff_sub, found;
    logic [13:0]       mx, myf, ys, n;
    logic [14:0]       sum;
    logic [3:0]        lz;
    logic [9:0]        mant, mant_r;
    logic              grd, stk, rnd;
    logic signed [7:0] e_base, e_n, e_rnd;
    logic [15:0]       res;
    logic [15:0]       pipe [LAT];

    always_comb begin
        // x is always the operand of larger magnitude, so ex >= ey and the
        // result takes the sign of x.
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex      = x[14:10];
        ey      = y[14:10];
        xnan    = (ex == 5'd31) && (x[9:0] != 10'd0);
        ynan    = (ey == 5'd31) && (y[9:0] != 10'd0);
        xi      = (ex == 5'd31) && (x[9:0] == 10'd0);
        yi      = (ey == 5'd31) && (y[9:0] == 10'd0);
        eff_sub = x[15] ^ y[15];
        d       = ex - ey;
        // Three extra bits below the mantissa: guard, round, and a sticky bit
        // that collects everything shifted out of the smaller operand.
        mx      = {1'b1, x[9:0], 3'b000};
        myf     = {1'b1, y[9:0], 3'b000};
        ys      = (d >= 5'd14) ? 14'd1
                : ((myf >> d) | {13'd0, |(myf & ~(14'h3FFF << d))});
        sum     = eff_sub ? ({1'b0, mx} - {1'b0, ys}) : ({1'b0, mx} + {1'b0, ys});

        lz    = 4'd0;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) found = 1'b1;
                else        lz = lz + 4'd1;
            end
        end

        e_base = $signed({3'b000, ex});
        if (sum[14]) begin
            n   = {sum[14:2], sum[1] | sum[0]};
            e_n = e_base + 8'sd1;
        end else begin
            n   = sum[13:0] << lz;
            e_n = e_base - $signed({4'b0000, lz});
        end
        mant   = n[12:3];
        grd    = n[2];
        stk    = n[1] | n[0];
        rnd    = grd & (stk | mant[0]);
        mant_r = mant + {9'd0, rnd};
        e_rnd  = (rnd && mant == 10'h3FF) ? e_n + 8'sd1 : e_n;

        if (xnan || ynan || (xi && yi && eff_sub)) res = 16'h7E00;
        else if (xi)                res = {x[15], 5'h1F, 10'h000};
        else if (ex == 5'd0)        res = {x[15] & y[15], 15'h0000};
        else if (ey == 5'd0)        res = x;
        else if (sum == 15'd0)      res = 16'h0000;
        else if (e_rnd >= 8'sd31)   res = {x[15], 5'h1F, 10'h000};
        else if (e_rnd <= 8'sd0)    res = {x[15], 15'h0000};
        else                        res = {x[15], e_rnd[4:0], mant_r};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= 16'h0000;
        end else begin
            pipe[0] <= res;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign s = pipe[LAT-1];
endmodule

module fp16_dot_mac #(
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_LAT    = 1,
    parameter int ADD_LAT    = 1
) (
    input  logic          CLK,
    input  logic          RESETn,
    fp16_dot_mac_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(MUL_LAT + 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [LEN_W-1:0] len_r, issued, consumed;
    logic [15:0]      acc;
    logic             acc_free;
    logic [MUL_LAT-1:0] mul_tag;
    logic [ADD_LAT-1:0] add_tag;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [INF_W-1:0] mul_inflight;
    logic [15:0]      product, sum;
    logic             in_hs, push, pop, retire, credit_ok;
    logic             start_run, start_done;

    fp16multiplier #(.LAT(MUL_LAT)) u_mul (
        .CLK    (CLK),
        .RESETn (RESETn),
        .a      (bus.a),
        .b      (bus.b),
        .p      (product)
    );

    fp16adder #(.LAT(ADD_LAT)) u_add (
        .CLK    (CLK),
        .RESETn (RESETn),
        .a      (acc),
        .b      (fifo_mem[rd_ptr]),
        .s      (sum)
    );

    // Products still inside the multiplier hold a FIFO credit, so a tag that
    // reaches the end of the shift register always finds a free slot.
    always_comb begin
        mul_inflight = '0;
        for (int i = 0; i < MUL_LAT; i++) mul_inflight = mul_inflight + INF_W'(mul_tag[i]);
        credit_ok = (int'(fifo_count) + int'(mul_inflight)) < FIFO_DEPTH;
    end

    assign bus.busy      = (state != IDLE);
    assign bus.in_ready  = (state == RUN) && (issued < len_r) && credit_ok;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = acc;
    assign in_hs         = bus.in_valid & bus.in_ready;
    assign push          = mul_tag[MUL_LAT-1];
    assign retire        = add_tag[ADD_LAT-1];
    assign pop           = (state == RUN) && acc_free && (fifo_count != '0);

    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        start_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_next = DONE;
                        start_done = 1'b1;
                    end else begin
                        state_next = RUN;
                        start_run  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (retire && (consumed + LEN_ONE) == len_r) state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            len_r      <= '0;
            issued     <= '0;
            consumed   <= '0;
            acc        <= 16'h0000;
            acc_free   <= 1'b1;
            mul_tag    <= '0;
            add_tag    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            mul_tag <= MUL_LAT'({mul_tag, in_hs});
            add_tag <= ADD_LAT'({add_tag, pop});

            if (start_run || start_done) begin
                len_r    <= bus.len;
                issued   <= '0;
                consumed <= '0;
                acc_free <= 1'b1;
                if (!bus.keep_acc) acc <= 16'h0000;
            end else begin
                if (in_hs) issued <= issued + LEN_ONE;
                // pop and retire are exclusive: pop needs acc_free, which is
                // low for the whole time an add is in flight.
                if (pop) acc_free <= 1'b0;
                if (retire) begin
                    acc      <= sum;
                    consumed <= consumed + LEN_ONE;
                    acc_free <= 1'b1;
                end
            end

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
            else if (pop && !push) fifo_count <= fifo_count - CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= product;
    end
endmodule

// File: tb/tb_fp16_dot_mac.sv
// tb/tb_fp16_dot_mac.sv - self-checking bench for fp16_dot_mac
module tb_fp16_dot_mac;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    fp16_dot_mac_if #(.LEN_W(8)) bus ();

    fp16_dot_mac #(.LEN_W(8), .FIFO_DEPTH(4), .MUL_LAT(1), .ADD_LAT(1)) dut (
        .CLK    (clk),
        .RESETn (resetn),
        .bus    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] pa [256];
    logic [15:0] pb [256];
    logic [15:0] model_acc;

    logic [15:0] r_data;
    int          r_hs, r_lat, r_vcnt;
    bit          r_drop, r_stable, r_extra, r_timeout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + h[9:0] / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        real  mag, m, fr;
        int   e, fl;
        logic s;
        if (v == 0.0) return 16'h0000;
        s   = (v < 0.0);
        mag = s ? -v : v;
        e   = 0;
        while (mag >= 2.0) begin mag = mag / 2.0; e++; end
        while (mag < 1.0)  begin mag = mag * 2.0; e--; end
        m  = mag * 1024.0;
        fl = $rtoi(m);
        fr = m - fl;
        if (fr > 0.5 || (fr == 0.5 && fl[0])) fl++;
        if (fl == 2048) begin fl = 1024; e++; end
        if (e + 15 >= 31) return {s, 5'h1F, 10'h000};
        if (e + 15 <= 0)  return {s, 15'h0000};
        return {s, 5'(e + 15), 10'(fl)};
    endfunction

    task automatic model_run(input int n, input bit keep);
        if (!keep) model_acc = 16'h0000;
        for (int i = 0; i < n; i++)
            model_acc = r2h(h2r(model_acc) + h2r(r2h(h2r(pa[i]) * h2r(pb[i]))));
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v[15]    = 1'($urandom_range(0, 1));
        v[14:10] = 5'($urandom_range(13, 17));
        v[9:0]   = 10'($urandom_range(0, 1023));
        return v;
    endfunction

    // Called just after a rising edge; returns just after the rising edge that
    // follows the output handshake.
    task automatic run_cmd(input int n, input bit keep, input int hold, input bit gaps,
                           input int busy_start_at);
        int idx, cyc;
        bit finished;
        idx = 0; cyc = 1; finished = 0;
        r_vcnt = 0; r_lat = -1; r_data = 16'hxxxx;
        r_drop = 0; r_stable = 1; r_extra = 0;
        bus.start = 1'b1; bus.len = 8'(n); bus.keep_acc = keep;
        @(posedge clk); #1;
        while (!finished && cyc < 3000) begin
            if (cyc == busy_start_at) begin
                bus.start = 1'b1; bus.len = 8'd5; bus.keep_acc = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            bus.in_valid  = (idx < n) && (!gaps || $urandom_range(0, 3) != 0);
            bus.a         = pa[idx & 255];
            bus.b         = pb[idx & 255];
            bus.out_ready = (r_vcnt >= hold);
            @(negedge clk);
            if (bus.in_ready && idx >= n) r_extra = 1;
            if (bus.busy && !bus.in_ready && idx < n && idx > 0) r_drop = 1;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid) begin
                if (r_vcnt == 0) begin
                    r_lat  = cyc;
                    r_data = bus.out_data;
                end else if (bus.out_data !== r_data) begin
                    r_stable = 0;
                end
                r_vcnt++;
                if (bus.out_ready) finished = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        r_hs      = idx;
        r_timeout = !finished;
    endtask

    task automatic check_cmd(input string tag, input int n, input logic [15:0] exp_data);
        check({tag, "_timeout"}, 32'(r_timeout), 32'd0);
        check({tag, "_data"}, {16'd0, r_data}, {16'd0, exp_data});
        check({tag, "_handshakes"}, r_hs, n);
        check({tag, "_stable"}, 32'(r_stable), 32'd1);
        check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int hs;
        resetn = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.keep_acc = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        model_acc = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", {16'd0, bus.out_data}, 32'h0000);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Basic dot product: 1*2 + 2*2 + 0.5*2 = 7.0
        pa[0] = 16'h3C00; pb[0] = 16'h4000;
        pa[1] = 16'h4000; pb[1] = 16'h4000;
        pa[2] = 16'h3800; pb[2] = 16'h4000;
        run_cmd(3, 1'b0, 0, 1'b0, -1);
        model_run(3, 1'b0);
        check_cmd("basic", 3, 16'h4700);
        check("basic_no_extra_ready", 32'(r_extra), 32'd0);

        // Keep-acc continuation: 7.0 + 1*1 = 8.0, handshake in 1, out_valid in 5
        pa[0] = 16'h3C00; pb[0] = 16'h3C00;
        run_cmd(1, 1'b1, 0, 1'b0, -1);
        model_run(1, 1'b1);
        check_cmd("keep", 1, 16'h4800);
        check("keep_latency", r_lat, 5);

        // Zero length
        run_cmd(0, 1'b0, 0, 1'b0, -1);
        model_run(0, 1'b0);
        check_cmd("zero", 0, 16'h0000);
        check("zero_latency", r_lat, 1);
        check("zero_no_in_ready", 32'(r_extra), 32'd0);

        // Back-pressure: eight 1*1 pairs, out_ready low for 5 valid cycles
        for (int i = 0; i < 8; i++) begin pa[i] = 16'h3C00; pb[i] = 16'h3C00; end
        run_cmd(8, 1'b0, 5, 1'b0, -1);
        model_run(8, 1'b0);
        check_cmd("bp", 8, 16'h4800);
        check("bp_ready_dropped", 32'(r_drop), 32'd1);
        check("bp_valid_cycles", r_vcnt, 6);

        // Start while busy: the len=5 keep=1 pulse in RUN must be ignored
        pa[0] = 16'h3C00; pb[0] = 16'h4000;
        pa[1] = 16'h4000; pb[1] = 16'h4000;
        pa[2] = 16'h3800; pb[2] = 16'h4000;
        run_cmd(3, 1'b0, 0, 1'b0, 2);
        model_run(3, 1'b0);
        check_cmd("busy_start", 3, 16'h4700);
        check("busy_start_no_extra_ready", 32'(r_extra), 32'd0);

        // Reset mid-run after 2 of 4 pairs; keep_acc=1 so out_data is 7.0 before reset
        bus.start = 1'b1; bus.len = 8'd4; bus.keep_acc = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.a = 16'h4000; bus.b = 16'h4000;
        hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            @(negedge clk);
            if (bus.in_ready) hs++;
            @(posedge clk); #1;
        end
        check("rst_two_handshakes", hs, 2);
        check("rst_pre_out_data", {16'd0, bus.out_data}, 32'h4700);
        resetn = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'h0000);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_acc = 16'h0000;
        @(posedge clk); #1;
        pa[0] = 16'h4000; pb[0] = 16'h4200;
        run_cmd(1, 1'b1, 0, 1'b0, -1);
        model_run(1, 1'b1);
        check_cmd("post_reset", 1, 16'h4600);

        // Randomized commands against the real-arithmetic reference
        for (int t = 0; t < 10; t++) begin
            int  n;
            bit  keep;
            n    = $urandom_range(0, 12);
            keep = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
            run_cmd(n, keep, $urandom_range(0, 3), 1'b1, -1);
            model_run(n, keep);
            check_cmd($sformatf("rand%0d", t), n, model_acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
